// File: rtl/vga_read_address_generator.sv
// VGA 640x480 timing plus 2x-upscaled frame-buffer read address generation.
// rd_addr is 1 clock after the counter position; rgb/hsync/vsync/blank are 3 clocks after.
module vga_read_address_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int ADDR_W   = 17,
  parameter int PIX_W    = 12
) (
  input  logic              CLK25,
  input  logic              rst,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  pix_in,
  output logic [PIX_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-2:0]     LINE_LAST = (VW-1)'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              h_end, v_end, active, hs_raw, vs_raw, fs_raw;

  logic [ADDR_W-1:0] rd_addr_q;
  logic              act_d1_q, hs_d1_q, vs_d1_q, fs_q;
  logic              act_d2_q, hs_d2_q, vs_d2_q;
  logic [PIX_W-1:0]  rgb_q;
  logic              hsync_q, vsync_q, blank_q;

  always_comb begin
    h_end  = (h_cnt_q == H_LAST);
    v_end  = (v_cnt_q == V_LAST);
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs_raw = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    fs_raw = (h_cnt_q == '0) && (v_cnt_q == '0);

    h_cnt_d = h_end ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    // addr_q always holds the address of the current position: base + h/2
    if (h_end) begin
      v_cnt_d = v_end ? '0 : v_cnt_q + VW'(1);
      if (v_end) begin
        base_d = '0;
      end else if (v_cnt_q[0] && (v_cnt_q[VW-1:1] < LINE_LAST)) begin
        base_d = base_q + LINE_STEP;
      end
      addr_d = base_d;
    end else if (h_cnt_q[0] && (h_cnt_q < H_ACT)) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK25 or posedge rst) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      act_d1_q  <= 1'b0;
      hs_d1_q   <= 1'b1;
      vs_d1_q   <= 1'b1;
      fs_q      <= 1'b0;
      act_d2_q  <= 1'b0;
      hs_d2_q   <= 1'b1;
      vs_d2_q   <= 1'b1;
      rgb_q     <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b1;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      rd_addr_q <= active ? addr_q : '0;
      act_d1_q  <= active;
      hs_d1_q   <= hs_raw;
      vs_d1_q   <= vs_raw;
      fs_q      <= fs_raw;
      // Second stage covers the RAM read latency so flags meet pix_in.
      act_d2_q  <= act_d1_q;
      hs_d2_q   <= hs_d1_q;
      vs_d2_q   <= vs_d1_q;
      rgb_q     <= act_d2_q ? pix_in : '0;
      hsync_q   <= hs_d2_q;
      vsync_q   <= vs_d2_q;
      blank_q   <= ~act_d2_q;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_read_address_generator.sv
// Bench for vga_read_address_generator on a reduced raster geometry.
module tb_vga_read_address_generator;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 2;
  localparam int IW = 8,  IH = 4;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NPIX = IW * IH;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] rd_addr;
  logic [11:0] pix_in, rgb;
  logic        hsync, vsync, blank, frame_start;
  logic [11:0] mem [NPIX];
  int          n = 0;
  int          checks = 0;
  int          passes = 0;

  typedef struct {
    int          cyc;
    logic [16:0] addr;
    logic        hs, vs, bl, fs;
  } vec_t;
  vec_t tbl [$];

  vga_read_address_generator #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(17), .PIX_W(12)
  ) dut (
    .CLK25(clk), .rst(rst), .rd_addr(rd_addr), .pix_in(pix_in), .rgb(rgb),
    .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Frame-buffer RAM with one clock of registered read latency.
  always @(posedge clk) pix_in <= (rd_addr < 17'(NPIX)) ? mem[rd_addr[4:0]] : 12'hbad;

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) $display("FAIL %s n=%0d got=%h want=%h", nm, n, got, want);
    else passes++;
  endtask

  // Expected {rd_addr, rgb, hsync, vsync, blank, frame_start} after edge cyc.
  function automatic logic [32:0] expect_at(input int cyc);
    int p, h, v;
    logic act;
    logic [16:0] a;
    logic [11:0] c;
    logic hs, vs, bl, fs;
    a = '0; c = '0; hs = 1'b1; vs = 1'b1; bl = 1'b1; fs = 1'b0;
    if (cyc >= 1) begin
      p = (cyc - 1) % FRAME; h = p % HT; v = p / HT;
      if (h < HA && v < VA) a = 17'((v / 2) * IW + h / 2);
      fs = (p == 0);
    end
    if (cyc >= 3) begin
      p = (cyc - 3) % FRAME; h = p % HT; v = p / HT;
      act = (h < HA) && (v < VA);
      if (act) c = mem[(v / 2) * IW + h / 2];
      hs = !(h >= HA + HFP && h < HA + HFP + HSW);
      vs = !(v >= VA + VFP && v < VA + VFP + VSW);
      bl = !act;
    end
    return {a, c, hs, vs, bl, fs};
  endfunction

  always @(negedge clk)
    chk("cycle", 64'({rd_addr, rgb, hsync, vsync, blank, frame_start}), 64'(expect_at(n)));

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME && !ok; i++) begin
      @(negedge clk);
      ok = frame_start;
    end
  endtask

  initial begin
    bit ok;
    int hs_lo, vs_lo, bl_lo, early, amax;

    rst = 1'b1;
    foreach (mem[i]) mem[i] = 12'(i);

    tbl.push_back('{1,   17'd0,  1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{2,   17'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{3,   17'd1,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{4,   17'd1,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{16,  17'd7,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{17,  17'd0,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{19,  17'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{21,  17'd0,  1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{23,  17'd0,  1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{24,  17'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{25,  17'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{40,  17'd7,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{50,  17'd8,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{184, 17'd31, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{218, 17'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{219, 17'd0,  1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{266, 17'd0,  1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{267, 17'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{313, 17'd0,  1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{315, 17'd1,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{316, 17'd1,  1'b1, 1'b1, 1'b0, 1'b0});

    repeat (3) @(negedge clk);
    chk("reset_state", 64'({rd_addr, rgb, hsync, vsync, blank, frame_start}),
        64'({17'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    #5 rst = 1'b0;

    foreach (tbl[i]) begin
      for (int g = 0; g < 2 * FRAME && n < tbl[i].cyc; g++) @(negedge clk);
      chk($sformatf("vec%0d", i), 64'({rd_addr, hsync, vsync, blank, frame_start}),
          64'({tbl[i].addr, tbl[i].hs, tbl[i].vs, tbl[i].bl, tbl[i].fs}));
    end

    // Whole-frame geometry measured between consecutive frame_start pulses.
    wait_fs(ok);
    chk("fs_found", 64'(ok), 64'(1));
    if (ok) begin
      hs_lo = 0; vs_lo = 0; bl_lo = 0; early = 0; amax = 0;
      for (int i = 0; i < FRAME; i++) begin
        hs_lo += int'(!hsync);
        vs_lo += int'(!vsync);
        bl_lo += int'(!blank);
        if (i > 0 && frame_start) early++;
        if (int'(rd_addr) > amax) amax = int'(rd_addr);
        @(negedge clk);
      end
      chk("fs_period", 64'(frame_start), 64'(1));
      chk("fs_early", 64'(early), 64'(0));
      chk("hs_low_clks", 64'(hs_lo), 64'(VT * HSW));
      chk("vs_low_clks", 64'(vs_lo), 64'(VSW * HT));
      chk("blank_low_clks", 64'(bl_lo), 64'(HA * VA));
      chk("addr_max", 64'(amax), 64'(NPIX - 1));
    end

    // Random mid-frame asynchronous resets with fresh random RAM contents.
    for (int it = 0; it < 6; it++) begin
      @(posedge clk);
      #($urandom_range(2, 17));
      rst = 1'b1;
      #1;
      chk("async_rst", 64'({rd_addr, rgb, hsync, vsync, blank, frame_start}),
          64'({17'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
      foreach (mem[i]) mem[i] = 12'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #5 rst = 1'b0;
      repeat ($urandom_range(40, 700)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
